// File: rtl/lcd8080_reg_if.sv
// 8080-style host bus slave: synchronised strobes, auto-incrementing register file and pixel-stream port.
// Define LCD8080_READBACK_EN to build the read path (J80_DOUT/J80_OE); otherwise both outputs are tied low.
module lcd8080_reg_if #(
  parameter int BUS_W     = 8,
  parameter int NUM_REGS  = 8,
  parameter int REG_W     = 8,
  parameter int PIX_BYTES = 2,
  parameter int PIX_ADDR  = 2,
  parameter int AUTO_INC  = 1
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic                          J80_CS_n,
  input  logic                          J80_RS,
  input  logic                          J80_WR_n,
  input  logic                          J80_RD_n,
  input  logic [BUS_W-1:0]              J80_DIN,
  output logic [BUS_W-1:0]              J80_DOUT,
  output logic                          J80_OE,
  output logic                          FIFOWe,
  output logic [PIX_BYTES*BUS_W-1:0]    FIFOData,
  input  logic                          FIFOFull,
  output logic [NUM_REGS*REG_W-1:0]     RegsFlat,
  output logic                          Ovf
);

  localparam int AW = $clog2(NUM_REGS);
  localparam int CW = (PIX_BYTES > 1) ? $clog2(PIX_BYTES) : 1;
  localparam int PW = PIX_BYTES * BUS_W;
  localparam int SW = BUS_W + 4;
  localparam logic [SW-1:0] SYNC_RST  = {1'b1, 1'b0, 1'b1, 1'b1, {BUS_W{1'b0}}};
  localparam logic [AW-1:0] PIX_A     = AW'(PIX_ADDR);
  localparam logic [CW-1:0] LAST_BYTE = CW'(PIX_BYTES - 1);

  // Sync vector layout: {cs_n, rs, wr_n, rd_n, din}
  logic [SW-1:0] sync1, sync2, sync3;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sync1 <= SYNC_RST;
      sync2 <= SYNC_RST;
      sync3 <= SYNC_RST;
    end else begin
      sync1 <= {J80_CS_n, J80_RS, J80_WR_n, J80_RD_n, J80_DIN};
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  logic             cs_s2, rs_s2, wr_s2, wr_s3;
  logic [BUS_W-1:0] din_s2;
  logic             wr_evt;
  logic             unused_sync;

  assign cs_s2  = sync2[BUS_W+3];
  assign rs_s2  = sync2[BUS_W+2];
  assign wr_s2  = sync2[BUS_W+1];
  assign wr_s3  = sync3[BUS_W+1];
  assign din_s2 = sync2[BUS_W-1:0];
  assign wr_evt = wr_s2 & ~wr_s3 & ~cs_s2;

  logic [REG_W-1:0] regs [NUM_REGS];
  logic [AW-1:0]    addr;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    pix;
  logic [PW-1:0]    pix_next;
  logic             addr_is_pix;

  assign addr_is_pix = (addr == PIX_A);
  assign pix_next    = PW'({pix, din_s2});

`ifdef LCD8080_READBACK_EN
  logic rd_s2, rd_s3;
  logic rd_start, rd_end;

  assign rd_s2 = sync2[BUS_W];
  assign rd_s3 = sync3[BUS_W];
  // A write seen in the same cycle wins; the read edge is simply lost.
  assign rd_start = rd_s3 & ~rd_s2 & ~cs_s2 & ~wr_evt;
  assign rd_end   = ~rd_s3 & rd_s2 & ~cs_s2 & ~wr_evt;
  assign unused_sync = ^{sync3[BUS_W+3], sync3[BUS_W+2], sync3[BUS_W-1:0]};
`else
  assign unused_sync = ^{sync3[BUS_W+3], sync3[BUS_W+2], sync3[BUS_W:0], sync2[BUS_W]};
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      addr     <= '0;
      cnt      <= '0;
      pix      <= '0;
      Ovf      <= 1'b0;
      FIFOWe   <= 1'b0;
      FIFOData <= '0;
    end else begin
      FIFOWe <= 1'b0;
      if (wr_evt) begin
        if (!rs_s2) begin
          addr <= din_s2[AW-1:0];
          cnt  <= '0;
          Ovf  <= 1'b0;
        end else if (addr_is_pix) begin
          pix <= pix_next;
          if (cnt == LAST_BYTE) begin
            cnt <= '0;
            if (FIFOFull) begin
              Ovf <= 1'b1;
            end else begin
              FIFOWe   <= 1'b1;
              FIFOData <= pix_next;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          regs[addr] <= din_s2[REG_W-1:0];
          if (AUTO_INC != 0) addr <= addr + 1'b1;
        end
      end
`ifdef LCD8080_READBACK_EN
      else if (rd_end && rs_s2 && !addr_is_pix && (AUTO_INC != 0)) begin
        addr <= addr + 1'b1;
      end
`endif
    end
  end

  always_comb begin
    RegsFlat = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) RegsFlat[i*REG_W +: REG_W] = regs[i];
  end

`ifdef LCD8080_READBACK_EN
  logic [CW+AW:0]   status;
  logic [BUS_W-1:0] rd_data;

  assign status = {Ovf, cnt, addr};

  always_comb begin
    rd_data = '0;
    if (!rs_s2)           rd_data = BUS_W'(status);
    else if (!addr_is_pix) rd_data = BUS_W'(regs[addr]);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      J80_DOUT <= '0;
      J80_OE   <= 1'b0;
    end else if (rd_start) begin
      J80_DOUT <= rd_data;
      J80_OE   <= 1'b1;
    end else if (rd_end || cs_s2) begin
      J80_OE <= 1'b0;
    end
  end
`else
  assign J80_DOUT = '0;
  assign J80_OE   = 1'b0;
`endif

endmodule

// File: tb/tb_lcd8080_reg_if.sv
// Directed bench for lcd8080_reg_if at default parameters; readback steps run when LCD8080_READBACK_EN is defined.
module tb_lcd8080_reg_if;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs_n, rs, wr_n, rd_n;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        oe;
  logic        fifo_we;
  logic [15:0] fifo_data;
  logic        fifo_full;
  logic [63:0] regs_flat;
  logic        ovf;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned pulses = 0;
  logic [15:0] pix_log [0:7];

  lcd8080_reg_if #(
    .BUS_W(8), .NUM_REGS(8), .REG_W(8), .PIX_BYTES(2), .PIX_ADDR(2), .AUTO_INC(1)
  ) dut (
    .CLK(clk), .nRST(rst_n),
    .J80_CS_n(cs_n), .J80_RS(rs), .J80_WR_n(wr_n), .J80_RD_n(rd_n), .J80_DIN(din),
    .J80_DOUT(dout), .J80_OE(oe),
    .FIFOWe(fifo_we), .FIFOData(fifo_data), .FIFOFull(fifo_full),
    .RegsFlat(regs_flat), .Ovf(ovf)
  );

  always #5 clk = ~clk;

  // Pixel-pulse monitor; one entry per cycle FIFOWe is high.
  always @(negedge clk) begin
    if (fifo_we) begin
      if (pulses < 8) pix_log[pulses] = fifo_data;
      pulses = pulses + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic r, input logic [7:0] d);
    @(negedge clk);
    cs_n = 1'b0; rs = r; din = d; wr_n = 1'b0;
    cycles(4);
    wr_n = 1'b1;
    cycles(5);
    cs_n = 1'b1;
    cycles(3);
  endtask

  task automatic bus_read(input logic r, output logic [7:0] d, output logic oe_mid, output logic oe_after);
    @(negedge clk);
    cs_n = 1'b0; rs = r; rd_n = 1'b0;
    cycles(5);
    d = dout; oe_mid = oe;
    rd_n = 1'b1;
    cycles(5);
    oe_after = oe;
    cs_n = 1'b1;
    cycles(3);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dout"}, 64'(dout), 64'h0);
    check({tag, "_oe"}, 64'(oe), 64'h0);
    check({tag, "_we"}, 64'(fifo_we), 64'h0);
    check({tag, "_data"}, 64'(fifo_data), 64'h0);
    check({tag, "_regs"}, regs_flat, 64'h0);
    check({tag, "_ovf"}, 64'(ovf), 64'h0);
  endtask

  initial begin
    logic [7:0] rdat;
    logic       oe_mid, oe_after;

    rst_n = 1'b0; cs_n = 1'b1; rs = 1'b0; wr_n = 1'b1; rd_n = 1'b1; din = '0; fifo_full = 1'b0;
    #1;
    check_reset_outputs("por");
    cycles(3);
    rst_n = 1'b1;
    cycles(2);

    // Register writes with auto-increment
    bus_write(1'b0, 8'h03);
    bus_write(1'b1, 8'h5A);
    bus_write(1'b1, 8'h11);
    check("reg3", 64'(regs_flat[31:24]), 64'h5A);
    check("reg4", 64'(regs_flat[39:32]), 64'h11);
    bus_write(1'b1, 8'h33);
    check("addr5_via_reg5", regs_flat, 64'h0000_3311_5A00_0000);

    // Wrap from last register to register 0
    bus_write(1'b0, 8'h07);
    bus_write(1'b1, 8'hAA);
    bus_write(1'b1, 8'hBB);
    check("wrap_regs", regs_flat, 64'hAA00_3311_5A00_00BB);

    // Pixel stream, MSB-first assembly, address pinned
    bus_write(1'b0, 8'h02);
    bus_write(1'b1, 8'h12);
    check("no_pulse_half_pixel", 64'(pulses), 64'd0);
    bus_write(1'b1, 8'h34);
    check("pulse_count_1", 64'(pulses), 64'd1);
    check("pix0", 64'(pix_log[0]), 64'h1234);
    bus_write(1'b1, 8'h56);
    bus_write(1'b1, 8'h78);
    check("pulse_count_2", 64'(pulses), 64'd2);
    check("pix1", 64'(pix_log[1]), 64'h5678);
    check("pix_regs_unchanged", regs_flat, 64'hAA00_3311_5A00_00BB);
    check("ovf_clear", 64'(ovf), 64'h0);

    // Downstream full: second pixel dropped, Ovf sticky until a command write
    bus_write(1'b0, 8'h02);
    bus_write(1'b1, 8'h12);
    bus_write(1'b1, 8'h34);
    check("pulse_count_3", 64'(pulses), 64'd3);
    check("pix2", 64'(pix_log[2]), 64'h1234);
    fifo_full = 1'b1;
    bus_write(1'b1, 8'h56);
    bus_write(1'b1, 8'h78);
    fifo_full = 1'b0;
    cycles(3);
    check("full_no_pulse", 64'(pulses), 64'd3);
    check("ovf_set", 64'(ovf), 64'h1);
    bus_write(1'b0, 8'h00);
    check("ovf_cleared_by_cmd", 64'(ovf), 64'h0);

    // Reset in the middle of a pixel
    bus_write(1'b0, 8'h02);
    bus_write(1'b1, 8'hEE);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    cycles(3);
    rst_n = 1'b1;
    cycles(6);
    check("no_pulse_after_reset", 64'(pulses), 64'd3);
`ifdef LCD8080_READBACK_EN
    bus_read(1'b0, rdat, oe_mid, oe_after);
    check("status_after_reset", 64'(rdat), 64'h00);
`endif
    bus_write(1'b0, 8'h02);
    bus_write(1'b1, 8'hCA);
    check("cafe_half", 64'(pulses), 64'd3);
    bus_write(1'b1, 8'hFE);
    check("cafe_pulse_count", 64'(pulses), 64'd4);
    check("cafe_data", 64'(pix_log[3]), 64'hCAFE);
    check("regs_after_reset", regs_flat, 64'h0);

`ifdef LCD8080_READBACK_EN
    bus_write(1'b0, 8'h03);
    bus_write(1'b1, 8'h5A);
    bus_write(1'b0, 8'h03);
    check("oe_idle", 64'(oe), 64'h0);
    bus_read(1'b1, rdat, oe_mid, oe_after);
    check("rd_data_reg3", 64'(rdat), 64'h5A);
    check("rd_oe_mid", 64'(oe_mid), 64'h1);
    check("rd_oe_after", 64'(oe_after), 64'h0);
    bus_read(1'b0, rdat, oe_mid, oe_after);
    check("status_addr4", 64'(rdat), 64'h04);

    // Chip select withdrawn while RD_n is still low
    @(negedge clk);
    cs_n = 1'b0; rs = 1'b1; rd_n = 1'b0;
    cycles(5);
    check("abort_oe_mid", 64'(oe), 64'h1);
    cs_n = 1'b1;
    cycles(4);
    check("abort_oe_dropped", 64'(oe), 64'h0);
    rd_n = 1'b1;
    cycles(4);
    bus_read(1'b0, rdat, oe_mid, oe_after);
    check("status_after_abort", 64'(rdat), 64'h04);

    // Status carries the partial byte count; pixel port reads as zero and never increments
    bus_write(1'b0, 8'h02);
    bus_write(1'b1, 8'h11);
    bus_read(1'b0, rdat, oe_mid, oe_after);
    check("status_partial", 64'(rdat), 64'h0A);
    bus_read(1'b1, rdat, oe_mid, oe_after);
    check("pix_port_read", 64'(rdat), 64'h00);
    bus_read(1'b0, rdat, oe_mid, oe_after);
    check("status_pix_no_inc", 64'(rdat), 64'h0A);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
